uart_cmd_ctrl: RTL and testbench
================================

Name: uart_cmd_ctrl

Overview:
Command controller between the UART receive/transmit pair and the display datapath (VGA test-pattern generator, dual 7-segment display). Parses a byte-oriented command stream from UART RX and updates the pattern and display registers. The pattern register is applied only at VGA frame boundaries. Each command is answered through UART TX with a handshake, so the UART is no longer a blind loopback.

Parameters:
CLKS_PER_BIT, 217, UART bit period in i_Clk cycles (25 MHz / 115200); documentation only, consistent with the UART instances.
TIMEOUT_CLKS, 34720, max idle clocks between command byte and argument byte (16 byte-times).
CMD_PATTERN, 8'h50, 'P': set pending pattern; 1 argument byte.
CMD_DISPLAY, 8'h44, 'D': set display byte; 1 argument byte.
CMD_READ, 8'h52, 'R': read back; no argument.

Ports:
i_Clk  in  1  system clock, 25 MHz
i_Rst  in  1  synchronous reset, active-high
i_RX_DV  in  1  one-cycle pulse; i_RX_Byte valid
i_RX_Byte  in  8  received byte
i_TX_Active  in  1  UART TX busy
i_TX_Done  in  1  one-cycle pulse at end of TX stop bit
i_Frame_Start  in  1  one-cycle pulse at first cycle of a VGA frame (row 0, col 0)
o_TX_DV  out  1  one-cycle pulse; o_TX_Byte is to be sent
o_TX_Byte  out  8  response byte, held stable until the next o_TX_DV
o_Pattern  out  4  applied test-pattern select
o_Display_Byte  out  8  value shown on the 7-segment pair
o_Busy  out  1  high in every state except IDLE
o_Err  out  1  one-cycle pulse on unknown command, timeout, or dropped byte

Behaviour:
- Clock and reset: single clock i_Clk; reset i_Rst is synchronous and active-high.
- Reset values: o_TX_DV=0, o_TX_Byte=0, o_Pattern=0, o_Display_Byte=0, o_Busy=0, o_Err=0; pending-valid flag=0; timeout counter=0; FSM=IDLE.
- A reset asserted mid-command or mid-response aborts it. An in-flight UART byte finishes on its own; the controller ignores the resulting i_TX_Done.
- FSM states: IDLE, WAIT_ARG, EXEC, TX_REQ, TX_WAIT.
- IDLE, i_RX_DV with CMD_PATTERN or CMD_DISPLAY: latch the opcode, clear the counter, go to WAIT_ARG.
- IDLE, i_RX_DV with CMD_READ: go to EXEC.
- IDLE, i_RX_DV with any other byte: pulse o_Err, queue response 8'h3F ('?'), go to TX_REQ.
- WAIT_ARG: counter increments each cycle.
  - i_RX_DV: latch the argument, go to EXEC.
  - Counter reaches TIMEOUT_CLKS-1 without i_RX_DV: pulse o_Err, return to IDLE, no response.
- EXEC (one cycle):
  - 'P': pending pattern <= arg[3:0], pending-valid <= 1.
  - 'D': o_Display_Byte <= arg.
  - 'P' and 'D' queue one response byte, 8'h4B ('K').
  - 'R' queues two bytes: {4'h0, o_Pattern} then o_Display_Byte. These are snapshotted in EXEC, so the applied pattern is reported, not the pending one.
  - Go to TX_REQ.
- Latency: argument byte accepted in cycle N -> EXEC in N+1 -> o_Display_Byte updated and visible from N+2.
- TX_REQ: when i_TX_Active=0, drive o_TX_Byte and pulse o_TX_DV for exactly one cycle, then go to TX_WAIT. If i_TX_Active=1, hold with o_TX_DV=0.
- TX_WAIT: on i_TX_Done, go to TX_REQ if a queued byte remains, otherwise go to IDLE.
- Response queue: depth 2, two byte registers plus a 2-bit count.
- Byte dropping: i_RX_DV in EXEC, TX_REQ or TX_WAIT drops the byte and pulses o_Err. There is no buffering.
- Frame-synchronous pattern:
  - On i_Frame_Start with pending-valid=1: o_Pattern <= pending, pending-valid <= 0.
  - An EXEC 'P' write in the same cycle as i_Frame_Start wins: pending takes the new value and pending-valid stays 1. The new value is applied at the next frame start; the old pending value is not applied.
  - Multiple 'P' commands within one frame: the last one wins.
- o_Display_Byte updates immediately, with no frame sync.
- o_Err pulses never stretch. If two error causes coincide in one cycle, o_Err is still a single pulse.

Decomposition:
- Package uart_cmd_pkg holds:
  - command codes (CMD_PATTERN, CMD_DISPLAY, CMD_READ);
  - response codes RSP_OK=8'h4B and RSP_ERR=8'h3F;
  - FSM state encoding (3 bits).
- One sub-module, cmd_timeout_counter: parameter TIMEOUT_CLKS; inputs i_Clk, i_Rst, i_Clear, i_Enable; output o_Expired (one-cycle pulse). Counter width is $clog2(TIMEOUT_CLKS).
- The FSM, response queue and pattern/display registers stay in uart_cmd_ctrl.

Test Plan:
- Reset, then RX 8'h44, 8'h A5 -> o_Display_Byte=8'hA5 two cycles after the second DV; exactly one o_TX_DV with o_TX_Byte=8'h4B; o_Busy returns to 0 after i_TX_Done.
- RX 8'h50, 8'h07 mid-frame -> o_Pattern stays 0 until the next i_Frame_Start, then becomes 4'h7. A second 'P' 8'h03 written in the same cycle as i_Frame_Start -> o_Pattern stays 7 for that frame and becomes 3 at the following frame start.
- After the above, RX 8'h52 -> two o_TX_DV pulses, each issued only after the previous i_TX_Done, with bytes 8'h07 then 8'hA5.
- RX 8'h5A -> one o_Err pulse, response 8'h3F; o_Pattern and o_Display_Byte unchanged.
- RX 8'h44, then silence for TIMEOUT_CLKS cycles -> o_Err pulse, FSM in IDLE, no o_TX_DV. A following 8'h44, 8'h11 -> display becomes 8'h11.
- Hold i_TX_Active=1 during a response; inject an RX byte while in TX_WAIT; assert i_Rst in TX_WAIT -> o_TX_DV held off while TX is active; injected byte dropped with an o_Err pulse; reset returns all outputs to reset values the next cycle, and the stale i_TX_Done is ignored.

Source files
------------

// File: rtl/uart_cmd_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : uart_cmd_pkg
//  Purpose  : Shared command codes, response codes and controller state
//             encoding for the UART command controller.
//  Revision : 1.0  initial release
// ============================================================================
package uart_cmd_pkg;

    // Command opcodes received from the UART
    localparam logic [7:0] CMD_PATTERN = 8'h50;  // 'P' + 1 argument byte
    localparam logic [7:0] CMD_DISPLAY = 8'h44;  // 'D' + 1 argument byte
    localparam logic [7:0] CMD_READ    = 8'h52;  // 'R', no argument

    // Response bytes sent back through the UART
    localparam logic [7:0] RSP_OK  = 8'h4B;      // 'K'
    localparam logic [7:0] RSP_ERR = 8'h3F;      // '?'

    // Controller state encoding
    localparam int         c_STATE_W     = 3;
    localparam logic [2:0] c_ST_IDLE     = 3'd0;
    localparam logic [2:0] c_ST_WAIT_ARG = 3'd1;
    localparam logic [2:0] c_ST_EXEC     = 3'd2;
    localparam logic [2:0] c_ST_TX_REQ   = 3'd3;
    localparam logic [2:0] c_ST_TX_WAIT  = 3'd4;

endpackage
`default_nettype wire

// File: rtl/cmd_timeout_counter.sv
`default_nettype none
// ============================================================================
//  Module   : cmd_timeout_counter
//  Purpose  : Idle counter between a command byte and its argument byte.
//             Counts while enabled and pulses o_Expired in the cycle the
//             count reaches TIMEOUT_CLKS-1.
//  Revision : 1.0  initial release
// ============================================================================
module cmd_timeout_counter #(
    parameter int TIMEOUT_CLKS = 34720
) (
    input  logic i_Clk,
    input  logic i_Rst,
    input  logic i_Clear,
    input  logic i_Enable,
    output logic o_Expired
);

    localparam int             c_W    = (TIMEOUT_CLKS > 1) ? $clog2(TIMEOUT_CLKS) : 1;
    localparam logic [c_W-1:0] c_LAST = c_W'(TIMEOUT_CLKS - 1);

    logic [c_W-1:0] r_count;

    // Expiry is decoded from the registered count so it lasts exactly one cycle
    assign o_Expired = i_Enable && (r_count == c_LAST);

    // Count enabled cycles; restart on clear or once the limit is reached
    always_ff @(posedge i_Clk) begin
        if (i_Rst || i_Clear) begin
            r_count <= '0;
        end else if (i_Enable) begin
            if (o_Expired) begin
                r_count <= '0;
            end else begin
                r_count <= r_count + 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/uart_cmd_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : uart_cmd_ctrl
//  Purpose  : Parses a byte command stream from UART RX, updates the pattern
//             and display registers, and answers every command via UART TX.
//             The pattern register is only applied at VGA frame starts.
//  Revision : 1.0  initial release
// ============================================================================
module uart_cmd_ctrl
    import uart_cmd_pkg::*;
#(
    parameter int CLKS_PER_BIT = 217,
    parameter int TIMEOUT_CLKS = 34720
) (
    input  logic       i_Clk,
    input  logic       i_Rst,
    input  logic       i_RX_DV,
    input  logic [7:0] i_RX_Byte,
    input  logic       i_TX_Active,
    input  logic       i_TX_Done,
    input  logic       i_Frame_Start,
    output logic       o_TX_DV,
    output logic [7:0] o_TX_Byte,
    output logic [3:0] o_Pattern,
    output logic [7:0] o_Display_Byte,
    output logic       o_Busy,
    output logic       o_Err
);

    // The bit period only documents the UART instances; reject nonsense values
    if (CLKS_PER_BIT < 1) begin : g_bad_clks_per_bit
        $error("CLKS_PER_BIT must be positive");
    end

    logic [c_STATE_W-1:0] r_state;
    logic [7:0]           r_opcode;
    logic [7:0]           r_arg;
    logic [7:0]           r_q0;          // next response byte to send
    logic [7:0]           r_q1;          // second response byte (read-back only)
    logic [1:0]           r_q_count;
    logic [3:0]           r_pending;
    logic                 r_pending_valid;

    logic w_expired;
    logic w_pat_write;
    logic w_drop;

    cmd_timeout_counter #(
        .TIMEOUT_CLKS (TIMEOUT_CLKS)
    ) u_timeout (
        .i_Clk     (i_Clk),
        .i_Rst     (i_Rst),
        .i_Clear   (r_state != c_ST_WAIT_ARG),
        .i_Enable  (r_state == c_ST_WAIT_ARG),
        .o_Expired (w_expired)
    );

    // A pattern write in EXEC takes priority over a coinciding frame start
    assign w_pat_write = (r_state == c_ST_EXEC) && (r_opcode == CMD_PATTERN);
    // No RX buffering: bytes arriving while a command is in progress are lost
    assign w_drop      = i_RX_DV && ((r_state == c_ST_EXEC)   ||
                                     (r_state == c_ST_TX_REQ) ||
                                     (r_state == c_ST_TX_WAIT));
    assign o_Busy      = (r_state != c_ST_IDLE);

    // Command FSM, response queue, frame-synchronous pattern and display registers
    always_ff @(posedge i_Clk) begin
        if (i_Rst) begin
            r_state         <= c_ST_IDLE;
            r_opcode        <= 8'h00;
            r_arg           <= 8'h00;
            r_q0            <= 8'h00;
            r_q1            <= 8'h00;
            r_q_count       <= 2'd0;
            r_pending       <= 4'h0;
            r_pending_valid <= 1'b0;
            o_TX_DV         <= 1'b0;
            o_TX_Byte       <= 8'h00;
            o_Pattern       <= 4'h0;
            o_Display_Byte  <= 8'h00;
            o_Err           <= 1'b0;
        end else begin
            o_TX_DV <= 1'b0;
            // Several error causes in one cycle still give a single pulse
            o_Err   <= w_drop;

            if (i_Frame_Start && r_pending_valid && !w_pat_write) begin
                o_Pattern       <= r_pending;
                r_pending_valid <= 1'b0;
            end

            case (r_state)
                c_ST_IDLE: begin
                    if (i_RX_DV) begin
                        r_opcode <= i_RX_Byte;
                        if ((i_RX_Byte == CMD_PATTERN) || (i_RX_Byte == CMD_DISPLAY)) begin
                            r_state <= c_ST_WAIT_ARG;
                        end else if (i_RX_Byte == CMD_READ) begin
                            r_state <= c_ST_EXEC;
                        end else begin
                            o_Err     <= 1'b1;
                            r_q0      <= RSP_ERR;
                            r_q_count <= 2'd1;
                            r_state   <= c_ST_TX_REQ;
                        end
                    end
                end

                c_ST_WAIT_ARG: begin
                    if (i_RX_DV) begin
                        r_arg   <= i_RX_Byte;
                        r_state <= c_ST_EXEC;
                    end else if (w_expired) begin
                        o_Err   <= 1'b1;
                        r_state <= c_ST_IDLE;
                    end
                end

                c_ST_EXEC: begin
                    r_state <= c_ST_TX_REQ;
                    if (r_opcode == CMD_PATTERN) begin
                        r_pending       <= r_arg[3:0];
                        r_pending_valid <= 1'b1;
                        r_q0            <= RSP_OK;
                        r_q_count       <= 2'd1;
                    end else if (r_opcode == CMD_DISPLAY) begin
                        o_Display_Byte <= r_arg;
                        r_q0           <= RSP_OK;
                        r_q_count      <= 2'd1;
                    end else if (r_opcode == CMD_READ) begin
                        // Report the applied pattern, not the pending one
                        r_q0      <= {4'h0, o_Pattern};
                        r_q1      <= o_Display_Byte;
                        r_q_count <= 2'd2;
                    end else begin
                        r_state <= c_ST_IDLE;
                    end
                end

                c_ST_TX_REQ: begin
                    if (!i_TX_Active) begin
                        o_TX_Byte <= r_q0;
                        o_TX_DV   <= 1'b1;
                        r_q0      <= r_q1;
                        r_q_count <= r_q_count - 2'd1;
                        r_state   <= c_ST_TX_WAIT;
                    end
                end

                c_ST_TX_WAIT: begin
                    if (i_TX_Done) begin
                        r_state <= (r_q_count != 2'd0) ? c_ST_TX_REQ : c_ST_IDLE;
                    end
                end

                default: r_state <= c_ST_IDLE;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_uart_cmd_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_uart_cmd_ctrl
//  Purpose  : Directed self-checking bench for uart_cmd_ctrl.
//  Revision : 1.0  initial release
// ============================================================================
module tb_uart_cmd_ctrl;

    localparam int c_TIMEOUT = 34720;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       rx_dv = 1'b0;
    logic [7:0] rx_byte = 8'h00;
    logic       tx_active = 1'b0;
    logic       tx_done = 1'b0;
    logic       frame_start = 1'b0;
    logic       tx_dv;
    logic [7:0] tx_byte;
    logic [3:0] pattern;
    logic [7:0] display_byte;
    logic       busy;
    logic       err;

    int n_checks = 0;
    int n_errors = 0;

    uart_cmd_ctrl #(
        .CLKS_PER_BIT (217),
        .TIMEOUT_CLKS (c_TIMEOUT)
    ) dut (
        .i_Clk          (clk),
        .i_Rst          (rst),
        .i_RX_DV        (rx_dv),
        .i_RX_Byte      (rx_byte),
        .i_TX_Active    (tx_active),
        .i_TX_Done      (tx_done),
        .i_Frame_Start  (frame_start),
        .o_TX_DV        (tx_dv),
        .o_TX_Byte      (tx_byte),
        .o_Pattern      (pattern),
        .o_Display_Byte (display_byte),
        .o_Busy         (busy),
        .o_Err          (err)
    );

    always #20 clk = ~clk;

    initial begin
        #20ms;
        $display("FAIL watchdog: simulation time limit reached, got no finish, expected finish");
        $fatal(1, "watchdog");
    end

    // Advance one clock; outputs are sampled 1 ns after the edge
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic rx_send(input logic [7:0] b);
        rx_dv   = 1'b1;
        rx_byte = b;
        tick();
        rx_dv   = 1'b0;
    endtask

    task automatic frame_pulse();
        frame_start = 1'b1;
        tick();
        frame_start = 1'b0;
    endtask

    task automatic wait_tx(input int budget, output bit seen, output logic [7:0] b);
        seen = 1'b0;
        b    = 8'h00;
        for (int i = 0; i < budget; i++) begin
            if (tx_dv === 1'b1) begin
                seen = 1'b1;
                b    = tx_byte;
                break;
            end
            tick();
        end
    endtask

    // Emulate the UART transmitting one byte, counting any extra TX_DV pulses
    task automatic finish_tx(output int extra);
        extra     = 0;
        tx_active = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            if (tx_dv !== 1'b0) extra++;
        end
        tx_active = 1'b0;
        tx_done   = 1'b1;
        tick();
        tx_done   = 1'b0;
        if (tx_dv !== 1'b0) extra++;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        n_checks++;
        if ({tx_dv, tx_byte, pattern, display_byte, busy, err} !== 23'h0) begin
            n_errors++;
            $display("FAIL reset_outputs: got dv=%b byte=%h pat=%h disp=%h busy=%b err=%b, expected all zero",
                     tx_dv, tx_byte, pattern, display_byte, busy, err);
        end
        rst = 1'b0;
        tick();
        n_checks++;
        if (busy !== 1'b0) begin
            n_errors++;
            $display("FAIL reset_idle: got busy=%b, expected 0", busy);
        end
    endtask

    task automatic test_display();
        bit         seen;
        logic [7:0] b;
        int         extra;
        rx_send(8'h44);
        n_checks++;
        if (busy !== 1'b1) begin
            n_errors++;
            $display("FAIL disp_busy: got %b, expected 1", busy);
        end
        rx_send(8'hA5);
        n_checks++;
        if (display_byte !== 8'h00) begin
            n_errors++;
            $display("FAIL disp_early: got %h, expected 00", display_byte);
        end
        tick();
        n_checks++;
        if (display_byte !== 8'hA5) begin
            n_errors++;
            $display("FAIL disp_value: got %h, expected a5", display_byte);
        end
        wait_tx(8, seen, b);
        n_checks++;
        if (!seen || b !== 8'h4B) begin
            n_errors++;
            $display("FAIL disp_rsp: got seen=%b byte=%h, expected seen=1 byte=4b", seen, b);
        end
        finish_tx(extra);
        n_checks++;
        if (extra != 0 || busy !== 1'b0) begin
            n_errors++;
            $display("FAIL disp_done: got extra_dv=%0d busy=%b, expected 0 and 0", extra, busy);
        end
    endtask

    task automatic test_pattern_apply();
        bit         seen;
        logic [7:0] b;
        int         extra;
        rx_send(8'h50);
        rx_send(8'h07);
        tick();
        wait_tx(8, seen, b);
        n_checks++;
        if (!seen || b !== 8'h4B) begin
            n_errors++;
            $display("FAIL pat_rsp: got seen=%b byte=%h, expected seen=1 byte=4b", seen, b);
        end
        finish_tx(extra);
        n_checks++;
        if (pattern !== 4'h0) begin
            n_errors++;
            $display("FAIL pat_before_frame: got %h, expected 0", pattern);
        end
        frame_pulse();
        n_checks++;
        if (pattern !== 4'h7) begin
            n_errors++;
            $display("FAIL pat_applied: got %h, expected 7", pattern);
        end
    endtask

    task automatic test_readback();
        bit         seen;
        logic [7:0] b;
        int         extra;
        rx_send(8'h52);
        tick();
        wait_tx(8, seen, b);
        n_checks++;
        if (!seen || b !== 8'h07) begin
            n_errors++;
            $display("FAIL read_byte0: got seen=%b byte=%h, expected seen=1 byte=07", seen, b);
        end
        tx_active = 1'b1;
        extra     = 0;
        for (int i = 0; i < 6; i++) begin
            tick();
            if (tx_dv !== 1'b0) extra++;
        end
        tx_active = 1'b0;
        tx_done   = 1'b1;
        tick();
        tx_done   = 1'b0;
        if (tx_dv !== 1'b0) extra++;
        n_checks++;
        if (extra != 0) begin
            n_errors++;
            $display("FAIL read_gap: got %0d early TX_DV pulses, expected 0", extra);
        end
        wait_tx(8, seen, b);
        n_checks++;
        if (!seen || b !== 8'hA5) begin
            n_errors++;
            $display("FAIL read_byte1: got seen=%b byte=%h, expected seen=1 byte=a5", seen, b);
        end
        finish_tx(extra);
        n_checks++;
        if (extra != 0 || busy !== 1'b0) begin
            n_errors++;
            $display("FAIL read_done: got extra_dv=%0d busy=%b, expected 0 and 0", extra, busy);
        end
    endtask

    task automatic test_pattern_coincide();
        bit         seen;
        logic [7:0] b;
        int         extra;
        rx_send(8'h50);
        rx_send(8'h0C);
        tick();
        wait_tx(8, seen, b);
        finish_tx(extra);
        rx_send(8'h50);
        rx_send(8'h03);
        frame_start = 1'b1;
        tick();
        frame_start = 1'b0;
        n_checks++;
        if (pattern !== 4'h7) begin
            n_errors++;
            $display("FAIL pat_coincide: got %h, expected 7", pattern);
        end
        wait_tx(8, seen, b);
        finish_tx(extra);
        frame_pulse();
        n_checks++;
        if (pattern !== 4'h3) begin
            n_errors++;
            $display("FAIL pat_last_wins: got %h, expected 3", pattern);
        end
    endtask

    task automatic test_unknown();
        bit         seen;
        logic [7:0] b;
        int         extra;
        rx_send(8'h5A);
        n_checks++;
        if (err !== 1'b1) begin
            n_errors++;
            $display("FAIL unk_err: got %b, expected 1", err);
        end
        tick();
        n_checks++;
        if (err !== 1'b0) begin
            n_errors++;
            $display("FAIL unk_err_width: got %b, expected 0", err);
        end
        wait_tx(8, seen, b);
        n_checks++;
        if (!seen || b !== 8'h3F) begin
            n_errors++;
            $display("FAIL unk_rsp: got seen=%b byte=%h, expected seen=1 byte=3f", seen, b);
        end
        finish_tx(extra);
        n_checks++;
        if (pattern !== 4'h3 || display_byte !== 8'hA5) begin
            n_errors++;
            $display("FAIL unk_regs: got pat=%h disp=%h, expected 3 and a5", pattern, display_byte);
        end
    endtask

    task automatic test_timeout();
        bit         seen;
        logic [7:0] b;
        int         extra;
        int         k;
        int         dv_seen;
        rx_send(8'h44);
        k       = 0;
        dv_seen = 0;
        for (int i = 1; i <= c_TIMEOUT + 20; i++) begin
            tick();
            if (tx_dv !== 1'b0) dv_seen++;
            if (err === 1'b1) begin
                k = i;
                break;
            end
        end
        n_checks++;
        if (k != c_TIMEOUT) begin
            n_errors++;
            $display("FAIL timeout_cycle: got err after %0d cycles, expected %0d", k, c_TIMEOUT);
        end
        n_checks++;
        if (busy !== 1'b0 || dv_seen != 0) begin
            n_errors++;
            $display("FAIL timeout_idle: got busy=%b tx_dv_count=%0d, expected 0 and 0", busy, dv_seen);
        end
        rx_send(8'h44);
        rx_send(8'h11);
        tick();
        n_checks++;
        if (display_byte !== 8'h11) begin
            n_errors++;
            $display("FAIL timeout_recover: got %h, expected 11", display_byte);
        end
        wait_tx(8, seen, b);
        finish_tx(extra);
    endtask

    task automatic test_reset_mid_tx();
        bit         seen;
        logic [7:0] b;
        int         extra;
        tx_active = 1'b1;
        rx_send(8'h44);
        rx_send(8'h22);
        tick();
        extra = 0;
        for (int i = 0; i < 5; i++) begin
            tick();
            if (tx_dv !== 1'b0) extra++;
        end
        n_checks++;
        if (extra != 0) begin
            n_errors++;
            $display("FAIL hold_off: got %0d TX_DV pulses while TX active, expected 0", extra);
        end
        tx_active = 1'b0;
        tick();
        n_checks++;
        if (tx_dv !== 1'b1 || tx_byte !== 8'h4B) begin
            n_errors++;
            $display("FAIL release_dv: got dv=%b byte=%h, expected 1 and 4b", tx_dv, tx_byte);
        end
        tx_active = 1'b1;
        rx_send(8'h33);
        n_checks++;
        if (err !== 1'b1 || busy !== 1'b1 || display_byte !== 8'h22) begin
            n_errors++;
            $display("FAIL drop_byte: got err=%b busy=%b disp=%h, expected 1 1 22", err, busy, display_byte);
        end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        n_checks++;
        if ({tx_dv, tx_byte, pattern, display_byte, busy, err} !== 23'h0) begin
            n_errors++;
            $display("FAIL mid_reset: got dv=%b byte=%h pat=%h disp=%h busy=%b err=%b, expected all zero",
                     tx_dv, tx_byte, pattern, display_byte, busy, err);
        end
        tx_active = 1'b0;
        tx_done   = 1'b1;
        tick();
        tx_done   = 1'b0;
        n_checks++;
        if (busy !== 1'b0 || tx_dv !== 1'b0) begin
            n_errors++;
            $display("FAIL stale_done: got busy=%b dv=%b, expected 0 and 0", busy, tx_dv);
        end
        frame_pulse();
        n_checks++;
        if (pattern !== 4'h0) begin
            n_errors++;
            $display("FAIL pending_cleared: got %h, expected 0", pattern);
        end
        rx_send(8'h44);
        rx_send(8'h77);
        tick();
        wait_tx(8, seen, b);
        n_checks++;
        if (display_byte !== 8'h77 || !seen || b !== 8'h4B) begin
            n_errors++;
            $display("FAIL post_reset_cmd: got disp=%h seen=%b byte=%h, expected 77 1 4b", display_byte, seen, b);
        end
        finish_tx(extra);
    endtask

    initial begin
        test_reset();
        test_display();
        test_pattern_apply();
        test_readback();
        test_pattern_coincide();
        test_unknown();
        test_timeout();
        test_reset_mid_tx();
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
